// File: rtl/niosii_sys_nios2_gen2_0_cpu_debug_ocimem_ctrl.sv
// OCI debug-RAM controller: executes JTAG read/write commands and shares the
// single-port debug RAM with a CPU Avalon-MM slave, JTAG taking priority.
module niosii_sys_nios2_gen2_0_cpu_debug_ocimem_ctrl #(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [37:0]       jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic              take_no_action_ocimem_a,
   input  logic [ADDR_W-1:0] avs_address,
   input  logic              avs_read,
   input  logic              avs_write,
   input  logic [31:0]       avs_writedata,
   output logic [31:0]       avs_readdata,
   output logic              avs_waitrequest,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_wren,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_q,
   output logic [31:0]       MonDReg,
   output logic              monitor_ready,
   output logic              monitor_error
);

   typedef enum logic [2:0] {IDLE, J_RD, J_CAP, J_WR, C_RD} state_t;
   typedef enum logic [1:0] {CMD_A, CMD_B, CMD_N} cmd_t;

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

   state_t            state_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic              pend_valid_reg;
   cmd_t              pend_cmd_reg;
   logic [37:0]       pend_jdo_reg;
   logic [31:0]       wdata_reg;
   logic              cpu_oor_reg;

   logic        idle, strobe_any, multi, exec_valid, addr_ok, cpu_ok;
   logic        cpu_wr_accept, cpu_rd_start, pend_store, pend_drop;
   logic        err_set, err_clr;
   cmd_t        new_cmd, exec_cmd;
   logic [37:0] exec_jdo;
   logic        unused_jdo_bits;

   assign idle       = (state_reg == IDLE);
   assign strobe_any = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
   assign multi      = (take_action_ocimem_a & take_action_ocimem_b) |
                       (take_action_ocimem_a & take_no_action_ocimem_a) |
                       (take_action_ocimem_b & take_no_action_ocimem_a);
   assign new_cmd    = take_action_ocimem_b ? CMD_B : (take_action_ocimem_a ? CMD_A : CMD_N);

   // A pending command always runs before a fresh strobe of the same IDLE cycle.
   assign exec_valid = idle & (pend_valid_reg | strobe_any);
   assign exec_cmd   = pend_valid_reg ? pend_cmd_reg : new_cmd;
   assign exec_jdo   = pend_valid_reg ? pend_jdo_reg : jdo;
   assign unused_jdo_bits = &{1'b0, exec_jdo[37:36], exec_jdo[2:0]};

   // The slot is refilled in the same IDLE cycle that drains it.
   assign pend_store = strobe_any & (idle ? pend_valid_reg : ~pend_valid_reg);
   assign pend_drop  = strobe_any & ~idle & pend_valid_reg;

   assign addr_ok       = {1'b0, addr_reg} < DEPTH_L;
   assign cpu_ok        = {1'b0, avs_address} < DEPTH_L;
   assign cpu_wr_accept = idle & ~exec_valid & avs_write & ~reset;
   assign cpu_rd_start  = idle & ~exec_valid & avs_read & ~avs_write;

   assign err_set = (strobe_any & multi) | pend_drop |
                    (((state_reg == J_CAP) | (state_reg == J_WR)) & ~addr_ok);
   assign err_clr = exec_valid & (exec_cmd == CMD_A) & exec_jdo[25];

   always_comb begin
      ram_addr        = '0;
      ram_wren        = 1'b0;
      ram_wdata       = '0;
      avs_waitrequest = 1'b0;
      avs_readdata    = '0;
      if (!reset) begin
         ram_addr        = avs_address;
         ram_wdata       = avs_writedata;
         avs_waitrequest = (avs_read | avs_write) & ~cpu_wr_accept & (state_reg != C_RD);
         case (state_reg)
            IDLE: ram_wren = cpu_wr_accept & cpu_ok;
            J_RD: ram_addr = addr_reg;
            J_WR: begin
               ram_addr  = addr_reg;
               ram_wdata = wdata_reg;
               ram_wren  = addr_ok;
            end
            C_RD: avs_readdata = cpu_oor_reg ? 32'h0 : ram_q;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= IDLE;
         addr_reg       <= '0;
         pend_valid_reg <= 1'b0;
         pend_cmd_reg   <= CMD_A;
         pend_jdo_reg   <= '0;
         wdata_reg      <= '0;
         cpu_oor_reg    <= 1'b0;
         MonDReg        <= '0;
         monitor_ready  <= 1'b0;
         monitor_error  <= 1'b0;
      end else begin
         monitor_error <= (monitor_error & ~err_clr) | err_set;

         if (pend_store) begin
            pend_valid_reg <= 1'b1;
            pend_cmd_reg   <= new_cmd;
            pend_jdo_reg   <= jdo;
         end else if (idle) begin
            pend_valid_reg <= 1'b0;
         end

         case (state_reg)
            IDLE: begin
               if (exec_valid) begin
                  case (exec_cmd)
                     CMD_A: begin
                        addr_reg      <= exec_jdo[ADDR_W+16:17];
                        monitor_ready <= 1'b0;
                        if (exec_jdo[35]) state_reg <= J_RD;
                     end
                     CMD_B: begin
                        wdata_reg <= exec_jdo[34:3];
                        state_reg <= J_WR;
                     end
                     default: state_reg <= J_RD;
                  endcase
               end else if (cpu_rd_start) begin
                  cpu_oor_reg <= ~cpu_ok;
                  state_reg   <= C_RD;
               end
            end
            J_RD: state_reg <= J_CAP;
            J_CAP: begin
               MonDReg       <= addr_ok ? ram_q : 32'h0;
               monitor_ready <= 1'b1;
               addr_reg      <= addr_reg + 1'b1;
               state_reg     <= IDLE;
            end
            J_WR: begin
               addr_reg  <= addr_reg + 1'b1;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_niosii_sys_nios2_gen2_0_cpu_debug_ocimem_ctrl.sv
// Bench for the OCI debug-RAM controller: directed scenarios plus a random
// command stream compared against a transaction-level model of the debug RAM.
module tb_niosii_sys_nios2_gen2_0_cpu_debug_ocimem_ctrl;
   localparam int ADDR_W = 8;
   localparam int DEPTH  = 200;

   logic clk = 1'b0;
   logic reset;
   logic [37:0] jdo;
   logic take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
   logic [ADDR_W-1:0] avs_address;
   logic avs_read, avs_write;
   logic [31:0] avs_writedata, avs_readdata;
   logic avs_waitrequest;
   logic [ADDR_W-1:0] ram_addr;
   logic ram_wren;
   logic [31:0] ram_wdata, ram_q;
   logic [31:0] MonDReg;
   logic monitor_ready, monitor_error;

   niosii_sys_nios2_gen2_0_cpu_debug_ocimem_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .jdo(jdo),
      .take_action_ocimem_a(take_action_ocimem_a),
      .take_action_ocimem_b(take_action_ocimem_b),
      .take_no_action_ocimem_a(take_no_action_ocimem_a),
      .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
      .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
      .avs_waitrequest(avs_waitrequest),
      .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_wdata(ram_wdata), .ram_q(ram_q),
      .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error)
   );

   always #5 clk = ~clk;

   // Behavioural single-port RAM with one-cycle read latency.
   logic [31:0] init_vals [256];
   logic [31:0] tb_ram [256];
   bit loaded;
   always @(posedge clk) begin
      if (!loaded) begin
         for (int i = 0; i < 256; i++) tb_ram[i] <= init_vals[i];
         loaded <= 1'b1;
      end else begin
         if (ram_wren) tb_ram[ram_addr] <= ram_wdata;
         ram_q <= tb_ram[ram_addr];
      end
   end

   // Reference model state
   logic [31:0] m_mem [256];
   logic [7:0]  m_addr;
   logic [31:0] m_mon;
   logic        m_ready, m_err;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      repeat (4) tick();
   endtask

   function automatic logic [37:0] jdo_a(input logic [7:0] a, input logic rd, input logic clr);
      logic [37:0] j;
      j = '0;
      j[24:17] = a;
      j[25] = clr;
      j[35] = rd;
      return j;
   endfunction

   function automatic logic [37:0] jdo_b(input logic [31:0] d);
      logic [37:0] j;
      j = '0;
      j[34:3] = d;
      return j;
   endfunction

   task automatic model_read();
      if (m_addr < DEPTH) m_mon = m_mem[m_addr];
      else begin
         m_mon = 32'h0;
         m_err = 1'b1;
      end
      m_ready = 1'b1;
      m_addr  = m_addr + 8'd1;
   endtask

   task automatic model_write(input logic [31:0] d);
      if (m_addr < DEPTH) m_mem[m_addr] = d;
      else m_err = 1'b1;
      m_addr = m_addr + 8'd1;
   endtask

   task automatic model_reset();
      m_addr = 8'd0;
      m_mon = 32'h0;
      m_ready = 1'b0;
      m_err = 1'b0;
   endtask

   task automatic check_mon(input string tag);
      check_val({tag, "_mon"}, MonDReg, m_mon);
      check_val({tag, "_rdy"}, 32'(monitor_ready), 32'(m_ready));
      check_val({tag, "_err"}, 32'(monitor_error), 32'(m_err));
   endtask

   // kind: 0 = ocimem_a, 1 = ocimem_b, 2 = no_action_ocimem_a
   task automatic jtag_strobe(input int kind, input logic [37:0] j);
      jdo = j;
      take_action_ocimem_a    = (kind == 0);
      take_action_ocimem_b    = (kind == 1);
      take_no_action_ocimem_a = (kind == 2);
      tick();
      take_action_ocimem_a    = 1'b0;
      take_action_ocimem_b    = 1'b0;
      take_no_action_ocimem_a = 1'b0;
      jdo = '0;
   endtask

   task automatic do_jtag_a(input logic [7:0] a, input logic rd, input logic clr);
      $display("txn jtag_a addr=%h rd=%0d clr=%0d", a, rd, clr);
      jtag_strobe(0, jdo_a(a, rd, clr));
      m_addr = a;
      m_ready = 1'b0;
      if (clr) m_err = 1'b0;
      if (rd) model_read();
      settle();
      check_mon("jtag_a");
   endtask

   task automatic do_jtag_b(input logic [31:0] d);
      $display("txn jtag_b data=%h", d);
      jtag_strobe(1, jdo_b(d));
      model_write(d);
      settle();
      check_mon("jtag_b");
   endtask

   task automatic do_jtag_n();
      $display("txn jtag_rdnext");
      jtag_strobe(2, '0);
      model_read();
      settle();
      check_mon("jtag_n");
   endtask

   task automatic do_cpu_wr(input logic [7:0] a, input logic [31:0] d);
      $display("txn cpu_wr addr=%h data=%h", a, d);
      avs_address = a;
      avs_writedata = d;
      avs_write = 1'b1;
      #1;
      check_val("cpu_wr_wait", 32'(avs_waitrequest), 32'd0);
      check_val("cpu_wr_wren", 32'(ram_wren), 32'(a < DEPTH));
      tick();
      avs_write = 1'b0;
      if (a < DEPTH) m_mem[a] = d;
   endtask

   // Assumes avs_read is already high; counts stalled cycles until data returns.
   task automatic cpu_rd_finish(output logic [31:0] got, output int cyc);
      bit done;
      done = 1'b0;
      got = '0;
      cyc = 0;
      for (int i = 0; i < 10 && !done; i++) begin
         #1;
         if (!avs_waitrequest) begin
            got = avs_readdata;
            done = 1'b1;
         end else begin
            cyc++;
            @(posedge clk);
            #1;
         end
      end
      check_val("cpu_rd_timeout", 32'(done), 32'd1);
      tick();
      avs_read = 1'b0;
   endtask

   task automatic do_cpu_rd(input logic [7:0] a);
      logic [31:0] got;
      int cyc;
      $display("txn cpu_rd addr=%h", a);
      avs_address = a;
      avs_read = 1'b1;
      cpu_rd_finish(got, cyc);
      check_val("cpu_rd_data", got, (a < DEPTH) ? m_mem[a] : 32'h0);
      check_val("cpu_rd_stall", 32'(cyc), 32'd1);
   endtask

   initial begin
      logic [31:0] got;
      int cyc;
      for (int i = 0; i < 256; i++) begin
         init_vals[i] = $urandom;
         m_mem[i] = init_vals[i];
      end
      model_reset();
      reset = 1'b1;
      jdo = '0;
      take_action_ocimem_a = 1'b0;
      take_action_ocimem_b = 1'b0;
      take_no_action_ocimem_a = 1'b0;
      avs_address = '0;
      avs_read = 1'b0;
      avs_write = 1'b0;
      avs_writedata = '0;
      repeat (3) tick();
      check_mon("reset");
      check_val("reset_wren", 32'(ram_wren), 32'd0);
      check_val("reset_wait", 32'(avs_waitrequest), 32'd0);
      reset = 1'b0;
      tick();

      // T1: read latency and post-increment
      do_cpu_wr(8'h05, 32'hDEADBEEF);
      $display("txn t1 jtag_a addr=05 rd=1");
      jtag_strobe(0, jdo_a(8'h05, 1'b1, 1'b0));
      check_val("t1_rdy_c1", 32'(monitor_ready), 32'd0);
      tick();
      check_val("t1_rdy_c2", 32'(monitor_ready), 32'd0);
      tick();
      check_val("t1_rdy_c3", 32'(monitor_ready), 32'd1);
      check_val("t1_mon_c3", MonDReg, 32'hDEADBEEF);
      m_addr = 8'h05;
      m_ready = 1'b0;
      model_read();
      settle();
      check_mon("t1");
      do_jtag_n();

      // T2: address load, write one cycle after strobe, read-next
      do_jtag_a(8'h10, 1'b0, 1'b0);
      $display("txn t2 jtag_b data=12345678");
      jtag_strobe(1, jdo_b(32'h12345678));
      check_val("t2_wren", 32'(ram_wren), 32'd1);
      check_val("t2_waddr", 32'(ram_addr), 32'h10);
      check_val("t2_wdata", ram_wdata, 32'h12345678);
      model_write(32'h12345678);
      settle();
      do_cpu_rd(8'h10);
      do_jtag_n();
      do_jtag_n();

      // T3: out-of-range read and write, then error clear
      do_jtag_a(8'hC8, 1'b1, 1'b0);
      $display("txn t3 jtag_b oor");
      jtag_strobe(1, jdo_b(32'hAAAA5555));
      check_val("t3_no_wren", 32'(ram_wren), 32'd0);
      model_write(32'hAAAA5555);
      settle();
      check_mon("t3_wr");
      do_jtag_a(8'h00, 1'b0, 1'b1);

      // T4: JTAG write beats a same-cycle CPU read of the same word
      do_jtag_a(8'h30, 1'b0, 1'b0);
      $display("txn t4 jtag_b + cpu_rd addr=30");
      jdo = jdo_b(32'hCAFE0123);
      take_action_ocimem_b = 1'b1;
      avs_address = 8'h30;
      avs_read = 1'b1;
      #1;
      check_val("t4_wait_c0", 32'(avs_waitrequest), 32'd1);
      @(posedge clk);
      #1;
      take_action_ocimem_b = 1'b0;
      jdo = '0;
      check_val("t4_wren", 32'(ram_wren), 32'd1);
      cpu_rd_finish(got, cyc);
      model_write(32'hCAFE0123);
      check_val("t4_rdata", got, 32'hCAFE0123);
      check_val("t4_stall", 32'(cyc), 32'd2);
      settle();

      // Simultaneous strobes: write wins, error flagged
      $display("txn multi-strobe b+n");
      jdo = jdo_b(32'h0BADF00D);
      take_action_ocimem_b = 1'b1;
      take_no_action_ocimem_a = 1'b1;
      tick();
      take_action_ocimem_b = 1'b0;
      take_no_action_ocimem_a = 1'b0;
      jdo = '0;
      model_write(32'h0BADF00D);
      m_err = 1'b1;
      settle();
      check_mon("multi");
      do_cpu_rd(8'h31);

      // T5: three back-to-back read-next strobes
      do_jtag_a(8'h40, 1'b0, 1'b1);
      $display("txn t5 three rdnext strobes");
      take_no_action_ocimem_a = 1'b1;
      repeat (3) tick();
      take_no_action_ocimem_a = 1'b0;
      model_read();
      model_read();
      m_err = 1'b1;
      settle();
      check_mon("t5");

      // T6a: reset while a JTAG read is in flight
      $display("txn t6 reset in J_RD");
      jtag_strobe(2, '0);
      reset = 1'b1;
      #1;
      model_reset();
      check_mon("t6a");
      check_val("t6a_wren", 32'(ram_wren), 32'd0);
      tick();
      reset = 1'b0;
      tick();
      do_jtag_n();

      // T6b: reset during the write cycle must suppress the write
      do_jtag_a(8'h20, 1'b0, 1'b0);
      $display("txn t6 reset in J_WR");
      jtag_strobe(1, jdo_b(32'h77777777));
      check_val("t6b_wren_pre", 32'(ram_wren), 32'd1);
      reset = 1'b1;
      #1;
      model_reset();
      check_val("t6b_wren", 32'(ram_wren), 32'd0);
      check_mon("t6b");
      tick();
      tick();
      reset = 1'b0;
      tick();
      do_cpu_rd(8'h20);
      do_jtag_n();

      // Random command stream
      for (int i = 0; i < 120; i++) begin
         case ($urandom_range(0, 4))
            0: do_jtag_a(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)));
            1: do_jtag_b($urandom);
            2: do_jtag_n();
            3: do_cpu_wr(8'($urandom_range(0, 255)), $urandom);
            default: do_cpu_rd(8'($urandom_range(0, 255)));
         endcase
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
